alu_multicycle: RTL and testbench

//  Parametrised BPF-VM ALU with the same op encoding as the single-cycle ALU.

---
 rtl/alu_multicycle.sv | 215 +++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: BPF-VM ALU with pipelined MUL and iterative DIV/MOD.
// Single-cycle ops finish in one edge; MUL/DIV run through MUL/DIV/DONE.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   A, B                  operands (accumulator, X/immediate)
//   ALU_sel               op select (0 add .. A xor, others give 0)
//   ALU_en, ALU_ack       request accept, result consumed
//   ALU_out               registered result
//   eq, gt, ge, set       unsigned predicates captured at accept
//   ALU_vld, ALU_busy     result valid (held to ack), op in flight
//   div_by_zero           last completed DIV/MOD had B == 0
module alu_multicycle #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_EN  = 1,
  parameter int PESS    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        ALU_sel,
  input  logic              ALU_en,
  input  logic              ALU_ack,
  output logic [DATA_W-1:0] ALU_out,
  output logic              eq,
  output logic              gt,
  output logic              ge,
  output logic              set,
  output logic              ALU_vld,
  output logic              ALU_busy,
  output logic              div_by_zero
);

  localparam int SW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CMAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [DATA_W-1:0] W_VAL   = DATA_W'(DATA_W);
  localparam logic [DATA_W-1:0] ERR_DIV = DATA_W'(32'hDEADBEEF);
  localparam logic [DATA_W-1:0] ERR_MOD = DATA_W'(32'hBEEFCAFE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic              accept;
  logic              is_mul;
  logic              is_div;
  logic              acc_multi;
  logic              acc_single;
  logic              fin;
  logic              ack_only;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] a_r, b_r;
  logic              mod_r;
  logic              b_zero;
  logic [DATA_W-1:0] quo, rem;
  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] mul_res;
  logic [DATA_W-1:0] fin_res;
  logic [DATA_W-1:0] single_res;
  logic [DATA_W-1:0] shl_res, shr_res;

  // Reserved parameter; present only so existing instantiations still bind.
  if (PESS != 0) begin : g_pess_rsvd
  end

  assign accept = ALU_en && (state == S_IDLE);
  assign is_mul = (ALU_sel == 4'h2);
  assign is_div = (DIV_EN != 0) &&
                  ((ALU_sel == 4'h3) || (ALU_sel == 4'h9));

  assign acc_multi  = accept && (is_mul || is_div);
  assign acc_single = accept && !(is_mul || is_div);
  assign ack_only   = ALU_ack && !accept && !fin;

  assign shl_res = (B >= W_VAL) ? '0 : (A << B[SW-1:0]);
  assign shr_res = (B >= W_VAL) ? '0 : (A >> B[SW-1:0]);

  always_comb begin
    single_res = '0;
    case (ALU_sel)
      4'h0: single_res = A + B;
      4'h1: single_res = A - B;
      4'h3: single_res = ERR_DIV;
      4'h4: single_res = A | B;
      4'h5: single_res = A & B;
      4'h6: single_res = shl_res;
      4'h7: single_res = shr_res;
      4'h8: single_res = ~A;
      4'h9: single_res = ERR_MOD;
      4'hA: single_res = A ^ B;
      default: single_res = '0;
    endcase
  end

  // Restoring step: bring in the next dividend bit, try subtracting.
  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, b_r};
  assign b_zero  = (b_r == '0);
  assign mul_res = a_r * b_r;

  always_comb begin
    fin_res = '0;
    if (state == S_MUL)
      fin_res = mul_res;
    else if (!b_zero)
      fin_res = mod_r ? rem : quo;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fin      = 1'b0;
    ALU_busy = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept && is_mul)
          state_nx = S_MUL;
        else if (accept && is_div)
          state_nx = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (cnt == '0) begin
          state_nx = S_DONE;
          fin      = 1'b1;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      mod_r       <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      ALU_out     <= '0;
      ALU_vld     <= 1'b0;
      div_by_zero <= 1'b0;
      eq          <= 1'b0;
      gt          <= 1'b0;
      ge          <= 1'b0;
      set         <= 1'b0;
    end else begin
      if (accept) begin
        a_r   <= A;
        b_r   <= B;
        mod_r <= (ALU_sel == 4'h9);
        eq    <= (A == B);
        gt    <= (A > B);
        ge    <= (A >= B);
        set   <= |(A & B);
      end

      if ((state == S_MUL || state == S_DIV) && cnt != '0)
        cnt <= cnt - CW'(1);

      if (state == S_DIV && cnt != '0) begin
        if (!diff[DATA_W]) begin
          rem <= diff[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], 1'b1};
        end else begin
          rem <= shifted[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], 1'b0};
        end
      end

      if (accept && is_mul)
        cnt <= CW'(MUL_LAT - 1);

      // A zero divisor still spends one dummy cycle so the result
      // lands two edges after accept; its quotient is forced to 0.
      if (accept && is_div) begin
        quo <= A;
        rem <= '0;
        cnt <= (B == '0) ? CW'(1) : CW'(DATA_W);
      end

      unique case (1'b1)
        acc_multi: ALU_vld <= 1'b0;
        acc_single: begin
          ALU_out <= single_res;
          ALU_vld <= 1'b1;
        end
        fin: begin
          ALU_out <= fin_res;
          ALU_vld <= 1'b1;
          if (state == S_DIV)
            div_by_zero <= b_zero;
        end
        ack_only: ALU_vld <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed scoreboard bench for alu_multicycle.
// Expected results are queued at issue and popped on ALU_vld.
module tb_alu_multicycle;

  localparam int W   = 32;
  localparam int ML  = 2;
  localparam int LIM = 200;

  logic         clk;
  logic         rst;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_sel;
  logic         ALU_en, ALU_ack;
  logic [W-1:0] ALU_out;
  logic         eq, gt, ge, set;
  logic         ALU_vld, ALU_busy, div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  alu_multicycle #(
    .DATA_W (W),
    .MUL_LAT(ML),
    .DIV_EN (1),
    .PESS   (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .ALU_sel    (ALU_sel),
    .ALU_en     (ALU_en),
    .ALU_ack    (ALU_ack),
    .ALU_out    (ALU_out),
    .eq         (eq),
    .gt         (gt),
    .ge         (ge),
    .set        (set),
    .ALU_vld    (ALU_vld),
    .ALU_busy   (ALU_busy),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [3:0]   s,
                       input logic [W-1:0] e);
    A       = a;
    B       = b;
    ALU_sel = s;
    ALU_en  = 1'b1;
    exp_q.push_back(e);
    step();
    ALU_en  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int cyc = 0;
    logic [W-1:0] e;
    while (!ALU_vld && cyc < LIM) begin
      step();
      cyc++;
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(lat));
    chk({tag, ".sbq"}, 64'(exp_q.size()), 64'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".out"}, 64'(ALU_out), 64'(e));
    end
  endtask

  task automatic ack(input string tag);
    ALU_ack = 1'b1;
    step();
    ALU_ack = 1'b0;
    chk({tag, ".ack"}, 64'(ALU_vld), 64'(0));
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [3:0]   s);
    logic [W-1:0] r;
    case (s)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h4: r = a | b;
      4'h5: r = a & b;
      4'h6: r = (b >= 32) ? '0 : a << b[4:0];
      4'h7: r = (b >= 32) ? '0 : a >> b[4:0];
      4'h8: r = ~a;
      4'hA: r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [W-1:0] ta[10];
  logic [W-1:0] tb_[10];
  logic [3:0]   ts[10];

  initial begin
    logic [3:0] pr;
    logic [W-1:0] e;
    bit seen;

    rst     = 1'b1;
    A       = '0;
    B       = '0;
    ALU_sel = '0;
    ALU_en  = 1'b0;
    ALU_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst.out", 64'(ALU_out), 64'(0));
    chk("rst.flags", 64'({ALU_vld, ALU_busy, div_by_zero}), 64'(0));
    chk("rst.pred", 64'({eq, gt, ge, set}), 64'(0));

    // 1: add, predicates, ack
    issue(5, 7, 4'h0, 12);
    wait_done("add", 0);
    chk("add.pred", 64'({eq, gt, ge, set}), 64'(4'b0001));
    ack("add");
    chk("add.hold", 64'(ALU_out), 64'(12));

    // 2: div / mod
    issue(1000, 3, 4'h3, 333);
    chk("div.busy", 64'({ALU_busy, ALU_vld}), 64'(2'b10));
    wait_done("div", W + 1);
    chk("div.pred", 64'({eq, gt, ge, set}), 64'(4'b0110));
    chk("div.dz", 64'(div_by_zero), 64'(0));
    ack("div");
    issue(1000, 3, 4'h9, 1);
    wait_done("mod", W + 1);
    ack("mod");

    // 3: divide by zero, then clear
    issue(9, 0, 4'h3, 0);
    wait_done("dz", 2);
    chk("dz.flag", 64'(div_by_zero), 64'(1));
    ack("dz");
    chk("dz.hold", 64'(div_by_zero), 64'(1));
    issue(9, 2, 4'h9, 1);
    wait_done("mod2", W + 1);
    chk("mod2.dz", 64'(div_by_zero), 64'(0));
    ack("mod2");

    // 4: mul with ignored requests, ack on completion edge
    A = 32'hFFFF_FFFF;
    B = 2;
    ALU_sel = 4'h2;
    ALU_en = 1'b1;
    exp_q.push_back(32'hFFFF_FFFE);
    step();
    A = 1;
    B = 1;
    ALU_sel = 4'h0;
    chk("mul.busy", 64'({ALU_busy, ALU_vld}), 64'(2'b10));
    step();
    ALU_en = 1'b0;
    chk("mul.wait", 64'({ALU_busy, ALU_vld}), 64'(2'b10));
    ALU_ack = 1'b1;
    step();
    ALU_ack = 1'b0;
    chk("mul.vld", 64'(ALU_vld), 64'(1));
    e = exp_q.pop_front();
    chk("mul.out", 64'(ALU_out), 64'(e));
    chk("mul.pred", 64'({eq, gt, ge, set}), 64'(4'b0111));
    ack("mul");
    seen = 1'b0;
    repeat (3) begin
      step();
      if (ALU_vld || ALU_busy) seen = 1'b1;
    end
    chk("mul.ignored", 64'(seen), 64'(0));

    // 5: shifts and single-cycle table
    issue(1, 40, 4'h6, 0);
    wait_done("shl40", 0);
    ack("shl40");
    issue(32'h80, 3, 4'h7, 32'h10);
    wait_done("shr3", 0);
    ack("shr3");

    ta  = '{0, 32'hF0F0, 32'hF0F0, 1, 1, 32'h8000_0000,
            32'h1234, 32'hAAAA_5555, 5, 5};
    tb_ = '{1, 32'h0FF0, 32'h0FF0, 31, 32, 31,
            7, 32'hFFFF_0000, 5, 5};
    ts  = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h6, 4'h7,
            4'h8, 4'hA, 4'hF, 4'hB};
    ts[0] = 4'h1;
    for (int i = 0; i < 10; i++) begin
      issue(ta[i], tb_[i], ts[i], model(ta[i], tb_[i], ts[i]));
      wait_done($sformatf("tbl%0d", i), 0);
      pr = {ta[i] == tb_[i], ta[i] > tb_[i],
            ta[i] >= tb_[i], (ta[i] & tb_[i]) != 0};
      chk($sformatf("tbl%0d.pred", i), 64'({eq, gt, ge, set}), 64'(pr));
      if (i == 9) begin
        issue(3, 5, 4'h2, 15);
        chk("mulclr.vld", 64'(ALU_vld), 64'(0));
        wait_done("mulclr", ML);
      end
      ack($sformatf("tbl%0d", i));
    end

    // 6: reset in the middle of a divide
    issue(1000, 3, 4'h3, 333);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst.out", 64'(ALU_out), 64'(0));
    chk("mrst.flags", 64'({ALU_vld, ALU_busy, div_by_zero}), 64'(0));
    chk("mrst.pred", 64'({eq, gt, ge, set}), 64'(0));
    exp_q.delete();
    seen = 1'b0;
    repeat (40) begin
      step();
      if (ALU_vld) seen = 1'b1;
    end
    chk("mrst.novld", 64'(seen), 64'(0));
    issue(2, 3, 4'h0, 5);
    wait_done("mrst.add", 0);
    ack("mrst.add");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
